// File: rtl/arb_mux_pipe_pkg.sv
// Shared definitions for the arbitrating operand mux.
//   arb_mode_e : arbitration mode encoding used for the MODE parameter
//   clog2_min1 : index width helper that never returns 0
package fpu_mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Index width for n items, at least one bit so a 1-entry index still
    // has a legal declaration.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_pipe_rr_arbiter.sv
// Combinational one-hot arbiter.
//   req   in  NCH  request vector
//   ptr   in  CW   round-robin start index (must be < NCH)
//   rr_en in  1    1: search starts at ptr and wraps; 0: lowest index wins
//   gnt   out NCH  one-hot grant, all zero when req is empty
module rr_arbiter
    import fpu_mux_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = clog2_min1(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    input  logic           rr_en,
    output logic [NCH-1:0] gnt
);

    logic          found;
    logic [CW-1:0] pos;
    int            sum;

    // Walk the channels in search order; the first requester wins. The
    // wrap is a single subtraction because ptr < NCH keeps sum < 2*NCH.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        sum   = 0;
        for (int off = 0; off < NCH; off++) begin
            sum = rr_en ? (int'(ptr) + off) : off;
            if (sum >= NCH) begin
                sum = sum - NCH;
            end
            pos = CW'(sum);
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_pipe.sv
// N-channel arbitrating mux with one registered valid/ready output stage.
//   clk, rst             clock; asynchronous active-high reset
//   in_data   in  NCH*DSIZE  channel i at [i*DSIZE +: DSIZE]
//   in_valid  in  NCH        per-channel request
//   in_ready  out NCH        per-channel accept (combinational)
//   force_en  in  1          restrict eligibility to channel force_sel
//   force_sel in  CW         forced channel (>= NCH means nobody eligible)
//   out_data  out DSIZE      registered selected data
//   out_ch    out CW         registered source channel index
//   out_valid out 1          output register holds valid data
//   out_ready in  1          downstream accept
//
// Handshake: a beat moves on a channel when valid and ready are both high
// at a rising clk edge; valid must not wait on ready. The output register
// reloads whenever it is empty or being drained this cycle, so a pop and a
// push in the same cycle keep full throughput with one cycle of latency.
module arb_mux_pipe
    import fpu_mux_pkg::*;
#(
    parameter  int DSIZE = 32,
    parameter  int NCH   = 4,
    parameter  int MODE  = 0,
    localparam int CW    = clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*DSIZE-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 force_en,
    input  logic [CW-1:0]        force_sel,
    output logic [DSIZE-1:0]     out_data,
    output logic [CW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam bit RR_MODE = (MODE == int'(ARB_RR));

    logic [DSIZE-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    ptr_q, ptr_d;

    logic [NCH-1:0]   elig;
    logic [NCH-1:0]   gnt;
    logic             load_en;
    logic             xfer;
    logic [DSIZE-1:0] sel_data;
    logic [CW-1:0]    sel_ch;

    // Forcing is a compare per channel, so an out-of-range force_sel
    // simply matches nothing and the eligible set is empty.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = in_valid[i] && (!force_en || (force_sel == CW'(i)));
        end
    end

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (elig),
        .ptr   (ptr_q),
        .rr_en (RR_MODE && !force_en),
        .gnt   (gnt)
    );

    // Held in reset, nothing is accepted so no producer loses a beat.
    assign load_en  = !rst && (!out_valid_q || out_ready);
    assign in_ready = load_en ? gnt : '0;
    assign xfer     = |in_ready;

    // AND-OR select over the one-hot grant.
    always_comb begin
        sel_data = '0;
        sel_ch   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | in_data[i*DSIZE +: DSIZE];
                sel_ch   = sel_ch | CW'(i);
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = sel_data;
            out_ch_d    = sel_ch;
            out_valid_d = 1'b1;
            if (RR_MODE) begin
                // Explicit wrap keeps ptr below NCH for non-power-of-two NCH.
                ptr_d = (sel_ch == CW'(NCH - 1)) ? '0 : sel_ch + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_pipe.sv
// Bench for arb_mux_pipe: three instances (fixed priority NCH=4, round-robin
// NCH=4, round-robin NCH=3 with 8-bit data) driven one at a time. Expected
// {channel, data} beats are queued as stimulus is applied and compared as
// each new output beat appears.
module tb_arb_mux_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [127:0] a_in_data, b_in_data;
    logic [3:0]   a_in_valid, a_in_ready, b_in_valid, b_in_ready;
    logic         a_force_en, b_force_en;
    logic [1:0]   a_force_sel, b_force_sel;
    logic [31:0]  a_out_data, b_out_data;
    logic [1:0]   a_out_ch, b_out_ch;
    logic         a_out_valid, b_out_valid, a_out_ready, b_out_ready;

    logic [23:0]  c_in_data;
    logic [2:0]   c_in_valid, c_in_ready;
    logic         c_force_en;
    logic [1:0]   c_force_sel;
    logic [7:0]   c_out_data;
    logic [1:0]   c_out_ch;
    logic         c_out_valid, c_out_ready;

    logic [39:0] exp_a_q[$];
    logic [39:0] exp_b_q[$];
    logic [39:0] exp_c_q[$];

    arb_mux_pipe #(.DSIZE(32), .NCH(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .force_en(a_force_en), .force_sel(a_force_sel),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
        .out_ready(a_out_ready)
    );

    arb_mux_pipe #(.DSIZE(32), .NCH(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .force_en(b_force_en), .force_sel(b_force_sel),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    arb_mux_pipe #(.DSIZE(8), .NCH(3), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .force_en(c_force_en), .force_sel(c_force_sel),
        .out_data(c_out_data), .out_ch(c_out_ch), .out_valid(c_out_valid),
        .out_ready(c_out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors: each beat is compared once, on the first falling
    // edge it is visible; it counts as consumed when out_ready is high.
    logic a_seen = 1'b0, b_seen = 1'b0, c_seen = 1'b0;
    logic [39:0] a_e, b_e, c_e;

    always @(negedge clk) begin
        if (rst) a_seen = 1'b0;
        else begin
            if (a_out_valid && !a_seen) begin
                if (exp_a_q.size() == 0) check("a_unexpected_beat", 1, 0);
                else begin
                    a_e = exp_a_q.pop_front();
                    check("a_out", {8'(a_out_ch), a_out_data}, a_e);
                end
                a_seen = 1'b1;
            end
            if (a_out_valid && a_out_ready) a_seen = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) b_seen = 1'b0;
        else begin
            if (b_out_valid && !b_seen) begin
                if (exp_b_q.size() == 0) check("b_unexpected_beat", 1, 0);
                else begin
                    b_e = exp_b_q.pop_front();
                    check("b_out", {8'(b_out_ch), b_out_data}, b_e);
                end
                b_seen = 1'b1;
            end
            if (b_out_valid && b_out_ready) b_seen = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) c_seen = 1'b0;
        else begin
            if (c_out_valid && !c_seen) begin
                if (exp_c_q.size() == 0) check("c_unexpected_beat", 1, 0);
                else begin
                    c_e = exp_c_q.pop_front();
                    check("c_out", {8'(c_out_ch), 32'(c_out_data)}, c_e);
                end
                c_seen = 1'b1;
            end
            if (c_out_valid && c_out_ready) c_seen = 1'b0;
        end
    end

    // One cycle on instance inst (0=a, 1=b, 2=c); the other instances idle.
    // Called just after a rising edge; returns just after the next one.
    task automatic drive(input int inst, input logic [3:0] v, input logic rdy,
                         input logic fe, input logic [1:0] fs, input logic [3:0] exp_rdy,
                         input bit push, input logic [7:0] ech, input logic [31:0] edat);
        a_in_valid = '0; a_out_ready = 1'b1; a_force_en = 1'b0; a_force_sel = '0;
        b_in_valid = '0; b_out_ready = 1'b1; b_force_en = 1'b0; b_force_sel = '0;
        c_in_valid = '0; c_out_ready = 1'b1; c_force_en = 1'b0; c_force_sel = '0;
        case (inst)
            0: begin
                a_in_valid = v; a_out_ready = rdy; a_force_en = fe; a_force_sel = fs;
                if (push) exp_a_q.push_back({ech, edat});
            end
            1: begin
                b_in_valid = v; b_out_ready = rdy; b_force_en = fe; b_force_sel = fs;
                if (push) exp_b_q.push_back({ech, edat});
            end
            default: begin
                c_in_valid = v[2:0]; c_out_ready = rdy; c_force_en = fe; c_force_sel = fs;
                if (push) exp_c_q.push_back({ech, edat});
            end
        endcase
        @(negedge clk);
        case (inst)
            0:       check("a_in_ready", a_in_ready, exp_rdy);
            1:       check("b_in_ready", b_in_ready, exp_rdy);
            default: check("c_in_ready", {1'b0, c_in_ready}, exp_rdy);
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_in_data = {32'h33, 32'h22, 32'h11, 32'h00};
        b_in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        c_in_data = {8'hC2, 8'hC1, 8'hC0};
        a_in_valid = '0; a_out_ready = 1'b1; a_force_en = 1'b0; a_force_sel = '0;
        b_in_valid = '0; b_out_ready = 1'b1; b_force_en = 1'b0; b_force_sel = '0;
        c_in_valid = '0; c_out_ready = 1'b1; c_force_en = 1'b0; c_force_sel = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_rst_valid", a_out_valid, 0);
        check("a_rst_data", a_out_data, 0);
        check("b_rst_ch", b_out_ch, 0);
        check("c_rst_valid", c_out_valid, 0);
        check("c_rst_data", c_out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fixed priority: ch1 beats ch3 while it stays valid
        repeat (3) drive(0, 4'b1010, 1, 0, 0, 4'b0010, 1, 8'd1, 32'h11);
        drive(0, 4'b1000, 1, 0, 0, 4'b1000, 1, 8'd3, 32'h33);
        drive(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0);
        check("a_drained_valid", a_out_valid, 0);
        check("a_hold_data", a_out_data, 32'h33);
        check("a_hold_ch", a_out_ch, 3);

        // Round-robin over all four, including the 3 -> 0 wrap
        for (int k = 0; k < 5; k++) begin
            check("b_ptr_rr", u_b.ptr_q, k % 4);
            drive(1, 4'hF, 1, 0, 0, 4'(1 << (k % 4)), 1, 8'(k % 4), 32'hA0 + 32'(k % 4));
        end

        // Backpressure: output held, nothing accepted
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'hF, 0, 0, 0, 4'b0000, 0, 0, 0);
            check("b_bp_valid", b_out_valid, 1);
            check("b_bp_data", b_out_data, 32'hA0);
            check("b_bp_ch", b_out_ch, 0);
        end
        check("b_ptr_bp", u_b.ptr_q, 1);
        drive(1, 4'hF, 1, 0, 0, 4'b0010, 1, 8'd1, 32'hA1);
        drive(1, 4'h0, 1, 0, 0, 4'b0000, 0, 0, 0);

        // Forced select in round-robin mode still advances ptr
        drive(1, 4'hF, 1, 1, 2'd2, 4'b0100, 1, 8'd2, 32'hA2);
        check("b_ptr_force", u_b.ptr_q, 3);
        drive(1, 4'h0, 1, 0, 0, 4'b0000, 0, 0, 0);

        // NCH=3, 8-bit: ptr wraps at 2 and never reaches 3
        for (int k = 0; k < 4; k++) begin
            check("c_ptr_rr", u_c.ptr_q, k % 3);
            drive(2, 4'b0111, 1, 0, 0, 4'(1 << (k % 3)), 1, 8'(k % 3), 32'hC0 + 32'(k % 3));
        end
        // Out-of-range force: nobody eligible, output drains
        drive(2, 4'b0111, 1, 1, 2'd3, 4'b0000, 0, 0, 0);
        drive(2, 4'b0111, 1, 1, 2'd3, 4'b0000, 0, 0, 0);
        check("c_force_oor_valid", c_out_valid, 0);
        check("c_ptr_oor", u_c.ptr_q, 1);

        // Mid-stream reset while a beat is held under backpressure
        drive(1, 4'hF, 1, 1, 2'd1, 4'b0010, 1, 8'd1, 32'hA1);
        check("b_ptr_pre_rst", u_b.ptr_q, 2);
        drive(1, 4'h0, 0, 0, 0, 4'b0000, 0, 0, 0);
        check("b_pre_rst_valid", b_out_valid, 1);
        rst = 1'b1;
        #2;
        check("b_mid_rst_valid", b_out_valid, 0);
        check("b_mid_rst_data", b_out_data, 0);
        check("b_mid_rst_ch", b_out_ch, 0);
        check("b_mid_rst_ptr", u_b.ptr_q, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 4'hF, 1, 0, 0, 4'b0001, 1, 8'd0, 32'hA0);
        drive(1, 4'h0, 1, 0, 0, 4'b0000, 0, 0, 0);

        check("a_queue_empty", exp_a_q.size(), 0);
        check("b_queue_empty", exp_b_q.size(), 0);
        check("c_queue_empty", exp_c_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
